// File: rtl/spi_slave_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_tx_scheduler
// Brief    : SPI slave transmit scheduler. Shares one MISO lane between
//            NUM_REQ word requesters with a round-robin grant per SPI word
//            and serialises the granted word per CPOL/CPHA and bit order.
// Options  : SPI_TX_UNDERRUN_CNT_EN adds underrun_clr / underrun_cnt[15:0].
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_tx_scheduler #(
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    NUM_REQ      = 4,
    parameter logic [DATA_WIDTH-1:0] FILL_PATTERN = 8'hFF
) (
    input  logic                          pclk,
    input  logic                          areset,
    input  logic                          cpol,
    input  logic                          cpha,
    input  logic                          msb_first,
    input  logic                          sclk,
    input  logic                          cs,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          miso0,
    output logic                          miso_oe,
    output logic                          frame_done,
    output logic                          frame_abort,
    output logic                          underrun
`ifdef SPI_TX_UNDERRUN_CNT_EN
    ,
    input  logic                          underrun_clr,
    output logic [15:0]                   underrun_cnt
`endif
);

    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(DATA_WIDTH) + 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Synchroniser / history chains for the asynchronous SPI pins
    logic sclk_meta_q, sclk_meta_d, sclk_sync_q, sclk_sync_d, sclk_hist_q, sclk_hist_d;
    logic cs_meta_q,   cs_meta_d,   cs_sync_q,   cs_sync_d,   cs_hist_q,   cs_hist_d;

    state_t                  state_q, state_d;
    logic [GW-1:0]           grant_id_q, grant_id_d;
    logic [CW-1:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    miso_q, miso_d;
    logic                    oe_q, oe_d;

    logic                    sclk_lead, sclk_trail, cs_fall, cs_rise;
    logic                    drive_edge, count_edge, word_end;
    logic [CW-1:0]           bit_cnt_inc;

    logic                    rr_found;
    logic [GW-1:0]           rr_win, rr_idx;
    logic [DATA_WIDTH-1:0]   rr_word, load_word;

    logic [NUM_REQ-1:0]      ready_w;
    logic                    done_w, abort_w, underrun_w;

    function automatic logic first_bit(input logic [DATA_WIDTH-1:0] w, input logic msb);
        return msb ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w,
                                                      input logic msb);
        return msb ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // Next values of the synchroniser chains: two stages plus one history stage
    always_comb begin
        sclk_meta_d = sclk;
        sclk_sync_d = sclk_meta_q;
        sclk_hist_d = sclk_sync_q;
        cs_meta_d   = cs;
        cs_sync_d   = cs_meta_q;
        cs_hist_d   = cs_sync_q;
    end

    // Edge classification relative to the idle level; in cpha=0 a trailing edge
    // seen before any leading edge of the word is the previous word's tail
    always_comb begin
        sclk_lead   = (sclk_hist_q == cpol) && (sclk_sync_q != cpol);
        sclk_trail  = (sclk_hist_q != cpol) && (sclk_sync_q == cpol);
        cs_fall     = cs_hist_q && !cs_sync_q;
        cs_rise     = !cs_hist_q && cs_sync_q;
        drive_edge  = cpha ? sclk_lead : (sclk_trail && (bit_cnt_q != '0));
        count_edge  = cpha ? sclk_trail : sclk_lead;
        bit_cnt_inc = bit_cnt_q + 1'b1;
        word_end    = count_edge && (bit_cnt_inc == CW'(DATA_WIDTH));
    end

    // Round-robin search starting one past the last granted requester
    always_comb begin
        rr_found = 1'b0;
        rr_win   = grant_id_q;
        rr_idx   = '0;
        rr_word  = FILL_PATTERN;
        for (int k = 1; k <= NUM_REQ; k++) begin
            rr_idx = GW'((32'(grant_id_q) + 32'(k)) % 32'(NUM_REQ));
            if (!rr_found && req_valid[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rr_win == GW'(i)) begin
                rr_word = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Transfer FSM: next state, datapath updates and pulse outputs
    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        miso_d     = miso_q;
        oe_d       = oe_q;
        load_word  = FILL_PATTERN;
        ready_w    = '0;
        done_w     = 1'b0;
        abort_w    = 1'b0;
        underrun_w = 1'b0;

        case (state_q)
            ST_IDLE: begin
                oe_d = 1'b0;
                if (cs_fall) begin
                    state_d = ST_LOAD;
                end
            end

            ST_LOAD: begin
                bit_cnt_d = '0;
                oe_d      = 1'b1;
                if (rr_found) begin
                    ready_w    = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_win;
                    grant_id_d = rr_win;
                    load_word  = rr_word;
                end else begin
                    underrun_w = 1'b1;
                end
                // cpha=0 presents the first bit before the first sampling edge
                if (!cpha) begin
                    miso_d  = first_bit(load_word, msb_first);
                    shift_d = advance(load_word, msb_first);
                end else begin
                    shift_d = load_word;
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    abort_w = 1'b1;
                    oe_d    = 1'b0;
                end else begin
                    state_d = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (drive_edge) begin
                    miso_d  = first_bit(shift_q, msb_first);
                    shift_d = advance(shift_q, msb_first);
                end
                if (count_edge) begin
                    bit_cnt_d = bit_cnt_inc;
                end
                // Completing the word wins over a simultaneous cs release
                if (word_end) begin
                    state_d = ST_DONE;
                end else if (cs_rise) begin
                    state_d = ST_IDLE;
                    abort_w = 1'b1;
                    oe_d    = 1'b0;
                end
            end

            ST_DONE: begin
                done_w = 1'b1;
                if (cs_sync_q) begin
                    state_d = ST_IDLE;
                    oe_d    = 1'b0;
                end else begin
                    state_d = ST_LOAD;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge pclk) begin
        if (!areset) begin
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_hist_q <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_sync_q   <= 1'b1;
            cs_hist_q   <= 1'b1;
            state_q     <= ST_IDLE;
            grant_id_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            miso_q      <= 1'b0;
            oe_q        <= 1'b0;
        end else begin
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_hist_q <= sclk_hist_d;
            cs_meta_q   <= cs_meta_d;
            cs_sync_q   <= cs_sync_d;
            cs_hist_q   <= cs_hist_d;
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            miso_q      <= miso_d;
            oe_q        <= oe_d;
        end
    end

`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic [15:0] underrun_cnt_q, underrun_cnt_d;

    // Saturating underrun event counter; clear has priority
    always_comb begin
        underrun_cnt_d = underrun_cnt_q;
        if (underrun_clr) begin
            underrun_cnt_d = '0;
        end else if (underrun_w && (underrun_cnt_q != 16'hFFFF)) begin
            underrun_cnt_d = underrun_cnt_q + 16'd1;
        end
    end

    // Underrun counter register
    always_ff @(posedge pclk) begin
        if (!areset) begin
            underrun_cnt_q <= '0;
        end else begin
            underrun_cnt_q <= underrun_cnt_d;
        end
    end

    assign underrun_cnt = underrun_cnt_q;
`endif

    assign req_ready   = ready_w;
    assign grant_id    = grant_id_q;
    assign miso0       = miso_q;
    assign miso_oe     = oe_q;
    assign frame_done  = done_w;
    assign frame_abort = abort_w;
    assign underrun    = underrun_w;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_tx_scheduler
// Brief    : Directed self-checking bench for spi_slave_tx_scheduler acting
//            as the SPI master and as the word requesters.
// Options  : SPI_TX_UNDERRUN_CNT_EN enables the underrun counter checks.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_tx_scheduler;

    logic        pclk = 1'b0;
    logic        areset, cpol, cpha, msb_first, sclk, cs;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic [1:0]  grant_id;
    logic        miso0, miso_oe, frame_done, frame_abort, underrun;
`ifdef SPI_TX_UNDERRUN_CNT_EN
    logic        underrun_clr;
    logic [15:0] underrun_cnt;
`endif

    spi_slave_tx_scheduler #(
        .DATA_WIDTH   (8),
        .NUM_REQ      (4),
        .FILL_PATTERN (8'hFF)
    ) dut (
        .pclk        (pclk),
        .areset      (areset),
        .cpol        (cpol),
        .cpha        (cpha),
        .msb_first   (msb_first),
        .sclk        (sclk),
        .cs          (cs),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .grant_id    (grant_id),
        .miso0       (miso0),
        .miso_oe     (miso_oe),
        .frame_done  (frame_done),
        .frame_abort (frame_abort),
        .underrun    (underrun)
`ifdef SPI_TX_UNDERRUN_CNT_EN
        ,
        .underrun_clr (underrun_clr),
        .underrun_cnt (underrun_cnt)
`endif
    );

    always #5 pclk = ~pclk;

    // Pulse monitors, sampled on the falling edge
    int n_done   = 0;
    int n_abort  = 0;
    int n_under  = 0;
    int n_rdy    = 0;
    int n_badrdy = 0;
    int glog [0:31];

    always @(negedge pclk) begin
        if (frame_done)  n_done++;
        if (frame_abort) n_abort++;
        if (underrun)    n_under++;
        if (req_ready != 4'b0000) begin
            for (int i = 0; i < 4; i++) begin
                if (req_ready[i]) glog[n_rdy % 32] = i;
            end
            if ($countones(req_ready) != 1) n_badrdy++;
            n_rdy++;
        end
    end

    int          n_checks = 0;
    int          n_fail   = 0;
    int          s_done, s_abort, s_under, s_rdy;
    logic [7:0]  rx [0:3];
    logic [7:0]  tmp;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge pclk);
    endtask

    task automatic snap();
        s_done  = n_done;
        s_abort = n_abort;
        s_under = n_under;
        s_rdy   = n_rdy;
    endtask

    // One master word of nbits; optionally release cs together with the final
    // counting edge so the word completes without a follow-on load
    task automatic xfer(input int nbits, input bit raise_cs, output logic [7:0] word);
        logic bitv;
        int   pos;
        word = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                wait_clk(6);
                bitv = miso0;
                sclk = ~cpol;
                if (raise_cs && (i == nbits - 1)) cs = 1'b1;
                wait_clk(6);
                sclk = cpol;
            end else begin
                wait_clk(6);
                sclk = ~cpol;
                wait_clk(6);
                bitv = miso0;
                sclk = cpol;
                if (raise_cs && (i == nbits - 1)) cs = 1'b1;
            end
            pos = msb_first ? 7 - i : i;
            word[pos] = bitv;
        end
        wait_clk(6);
    endtask

    task automatic run_frame(input int nwords);
        cs = 1'b0;
        wait_clk(5);
        check_val("oe_on", 32'(miso_oe), 32'd1);
        for (int k = 0; k < nwords; k++) begin
            xfer(8, (k == nwords - 1), rx[k]);
        end
        wait_clk(4);
    endtask

    initial begin
        areset    = 1'b0;
        cpol      = 1'b0;
        cpha      = 1'b0;
        msb_first = 1'b1;
        sclk      = 1'b0;
        cs        = 1'b1;
        req_valid = 4'b0000;
        req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};
`ifdef SPI_TX_UNDERRUN_CNT_EN
        underrun_clr = 1'b0;
`endif
        wait_clk(4);

        // Reset state
        check_val("rst_miso",  32'(miso0), 32'd0);
        check_val("rst_oe",    32'(miso_oe), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        check_val("rst_grant", 32'(grant_id), 32'd0);
        check_val("rst_flags", 32'({frame_done, frame_abort, underrun}), 32'd0);
        areset = 1'b1;
        wait_clk(4);

        // Mode 0, MSB first, only requester 0 valid
        req_valid = 4'b0001;
        snap();
        run_frame(1);
        check_val("A_word",  32'(rx[0]), 32'hA5);
        check_val("A_rdy",   32'(n_rdy - s_rdy), 32'd1);
        check_val("A_gnt",   32'(glog[s_rdy % 32]), 32'd0);
        check_val("A_done",  32'(n_done - s_done), 32'd1);
        check_val("A_abort", 32'(n_abort - s_abort), 32'd0);
        check_val("A_oe",    32'(miso_oe), 32'd0);

        // Mode 3, LSB first, only requester 2 valid
        cpol      = 1'b1;
        sclk      = 1'b1;
        cpha      = 1'b1;
        msb_first = 1'b0;
        req_data  = {8'h44, 8'h3C, 8'h22, 8'h11};
        req_valid = 4'b0100;
        wait_clk(6);
        snap();
        run_frame(1);
        check_val("B_word",  32'(rx[0]), 32'h3C);
        check_val("B_gntid", 32'(grant_id), 32'd2);
        check_val("B_done",  32'(n_done - s_done), 32'd1);

        // Four back-to-back words, all requesters valid, from reset
        areset    = 1'b0;
        cpol      = 1'b0;
        sclk      = 1'b0;
        cpha      = 1'b0;
        msb_first = 1'b1;
        req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        req_valid = 4'b1111;
        wait_clk(2);
        areset = 1'b1;
        wait_clk(6);
        snap();
        run_frame(4);
        check_val("C_w0",   32'(rx[0]), 32'h22);
        check_val("C_w1",   32'(rx[1]), 32'h33);
        check_val("C_w2",   32'(rx[2]), 32'h44);
        check_val("C_w3",   32'(rx[3]), 32'h11);
        check_val("C_g0",   32'(glog[(s_rdy + 0) % 32]), 32'd1);
        check_val("C_g1",   32'(glog[(s_rdy + 1) % 32]), 32'd2);
        check_val("C_g2",   32'(glog[(s_rdy + 2) % 32]), 32'd3);
        check_val("C_g3",   32'(glog[(s_rdy + 3) % 32]), 32'd0);
        check_val("C_rdy",  32'(n_rdy - s_rdy), 32'd4);
        check_val("C_done", 32'(n_done - s_done), 32'd4);

        // Underrun: nobody valid
        req_valid = 4'b0000;
        wait_clk(2);
        snap();
        run_frame(1);
        check_val("D_word",  32'(rx[0]), 32'hFF);
        check_val("D_under", 32'(n_under - s_under), 32'd1);
        check_val("D_rdy",   32'(n_rdy - s_rdy), 32'd0);
        check_val("D_gntid", 32'(grant_id), 32'd0);
`ifdef SPI_TX_UNDERRUN_CNT_EN
        check_val("D_cnt1", 32'(underrun_cnt), 32'd1);
        force dut.underrun_cnt_q = 16'hFFFE;
        wait_clk(1);
        release dut.underrun_cnt_q;
        wait_clk(1);
        run_frame(1);
        check_val("D_cntA", 32'(underrun_cnt), 32'hFFFF);
        run_frame(1);
        check_val("D_sat",  32'(underrun_cnt), 32'hFFFF);
        underrun_clr = 1'b1;
        wait_clk(1);
        underrun_clr = 1'b0;
        wait_clk(1);
        check_val("D_clr",  32'(underrun_cnt), 32'd0);
`endif

        // Abort after three bits, then the next frame continues the rotation
        req_valid = 4'b1111;
        wait_clk(2);
        snap();
        cs = 1'b0;
        wait_clk(5);
        xfer(3, 1'b0, tmp);
        cs = 1'b1;
        wait_clk(8);
        check_val("E_bits",  32'(tmp[7:5]), 32'h1);
        check_val("E_abort", 32'(n_abort - s_abort), 32'd1);
        check_val("E_done",  32'(n_done - s_done), 32'd0);
        check_val("E_oe",    32'(miso_oe), 32'd0);
        check_val("E_gnt",   32'(glog[s_rdy % 32]), 32'd1);
        snap();
        run_frame(1);
        check_val("E_next",  32'(rx[0]), 32'h33);
        check_val("E_gntid", 32'(grant_id), 32'd2);

        // Reset in the middle of a word
        snap();
        cs = 1'b0;
        wait_clk(5);
        xfer(5, 1'b0, tmp);
        check_val("F_bits", 32'(tmp[7:3]), 32'h08);
        areset = 1'b0;
        cs     = 1'b1;
        sclk   = cpol;
        wait_clk(1);
        check_val("F_miso",  32'(miso0), 32'd0);
        check_val("F_oe",    32'(miso_oe), 32'd0);
        check_val("F_grant", 32'(grant_id), 32'd0);
        check_val("F_ready", 32'(req_ready), 32'd0);
        check_val("F_flags", 32'({frame_done, frame_abort, underrun}), 32'd0);
        areset = 1'b1;
        wait_clk(6);
        snap();
        run_frame(1);
        check_val("F_word", 32'(rx[0]), 32'h22);
        check_val("F_gnt",  32'(glog[s_rdy % 32]), 32'd1);

        check_val("onehot_rdy", 32'(n_badrdy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
